// File: rtl/wishbone_arbiter_pkg.sv
// Shared types for the two-master Wishbone arbiter: FSM states, requester ids, grant encodings.
package wishbone_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } requester_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_I    = 2'b01;
    localparam logic [1:0] GRANT_D    = 2'b10;

endpackage

// File: rtl/wishbone_watchdog.sv
// Per-transaction watchdog: counts owned cycles without ACK/RTY and flags expiry on the last allowed cycle.
module wishbone_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    input  logic done,
    output logic expired
);

    localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    generate
        if (TIMEOUT > 0) begin : g_wd
            localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
            localparam logic [W-1:0] SAT  = W'(TIMEOUT);
            logic [W-1:0] wd_cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wd_cnt <= '0;
                end else if (clear) begin
                    wd_cnt <= '0;
                end else if (enable && !done && (wd_cnt != SAT)) begin
                    wd_cnt <= wd_cnt + W'(1);
                end
            end

            // Expiry never overrides a same-cycle completion.
            assign expired = enable & ~done & (wd_cnt == LAST);
        end else begin : g_off
            assign expired = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/wishbone_arbiter.sv
// Round-robin arbiter: I-cache and D-cache share one Wishbone master port, one transaction at a time.
//   state | meaning
//   IDLE  | no owner; mem port driven to zero; arbitration decision registered here
//   OWN_I | I-cache owns the mem port until ACK/RTY, abort or watchdog expiry
//   OWN_D | D-cache owns the mem port until ACK/RTY, abort or watchdog expiry
module wishbone_arbiter
    import wishbone_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 27,
    parameter int TIMEOUT    = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic [DATA_WIDTH-1:0]   icache_dat_m,
    input  logic                    icache_cyc,
    input  logic                    icache_stb,
    input  logic                    icache_we,
    input  logic [DATA_WIDTH/8-1:0] icache_sel,
    input  logic [ADDR_WIDTH-1:0]   icache_adr,
    output logic [DATA_WIDTH-1:0]   icache_dat_s,
    output logic                    icache_ack,
    output logic                    icache_rty,

    input  logic [DATA_WIDTH-1:0]   dcache_dat_m,
    input  logic                    dcache_cyc,
    input  logic                    dcache_stb,
    input  logic                    dcache_we,
    input  logic [DATA_WIDTH/8-1:0] dcache_sel,
    input  logic [ADDR_WIDTH-1:0]   dcache_adr,
    output logic [DATA_WIDTH-1:0]   dcache_dat_s,
    output logic                    dcache_ack,
    output logic                    dcache_rty,

    output logic [DATA_WIDTH-1:0]   mem_dat_m,
    output logic                    mem_cyc,
    output logic                    mem_stb,
    output logic                    mem_we,
    output logic [DATA_WIDTH/8-1:0] mem_sel,
    output logic [ADDR_WIDTH-1:0]   mem_adr,
    input  logic [DATA_WIDTH-1:0]   mem_dat_s,
    input  logic                    mem_ack,
    input  logic                    mem_rty,

    output logic [1:0]              grant,
    output logic                    timeout_err
);

    arb_state_t state, state_nxt;
    requester_t last, last_nxt;
    logic       i_req, d_req, own_cyc, xfer_done, wd_expired;

    assign i_req     = icache_cyc & icache_stb;
    assign d_req     = dcache_cyc & dcache_stb;
    assign own_cyc   = (state == OWN_I) ? icache_cyc :
                       (state == OWN_D) ? dcache_cyc : 1'b0;
    assign xfer_done = mem_ack | mem_rty;

    wishbone_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state == IDLE),
        .enable  (own_cyc),
        .done    (xfer_done),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last        <= ICACHE;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            if (wd_expired) timeout_err <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (i_req && d_req)  state_nxt = (last == ICACHE) ? OWN_D : OWN_I;
                else if (d_req)      state_nxt = OWN_D;
                else if (i_req)      state_nxt = OWN_I;
            end
            OWN_I: begin
                if (!own_cyc || xfer_done || wd_expired) begin
                    state_nxt = IDLE;
                    last_nxt  = ICACHE;
                end
            end
            OWN_D: begin
                if (!own_cyc || xfer_done || wd_expired) begin
                    state_nxt = IDLE;
                    last_nxt  = DCACHE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_dat_m    = '0;
        mem_cyc      = 1'b0;
        mem_stb      = 1'b0;
        mem_we       = 1'b0;
        mem_sel      = '0;
        mem_adr      = '0;
        icache_dat_s = '0;
        icache_ack   = 1'b0;
        icache_rty   = 1'b0;
        dcache_dat_s = '0;
        dcache_ack   = 1'b0;
        dcache_rty   = 1'b0;
        grant        = GRANT_NONE;
        case (state)
            OWN_I: begin
                grant        = GRANT_I;
                mem_dat_m    = icache_dat_m;
                mem_cyc      = icache_cyc & ~wd_expired;
                mem_stb      = icache_stb & ~wd_expired;
                mem_we       = icache_we;
                mem_sel      = icache_sel;
                mem_adr      = icache_adr;
                icache_dat_s = mem_dat_s;
                icache_ack   = mem_ack;
                icache_rty   = mem_rty | wd_expired;
            end
            OWN_D: begin
                grant        = GRANT_D;
                mem_dat_m    = dcache_dat_m;
                mem_cyc      = dcache_cyc & ~wd_expired;
                mem_stb      = dcache_stb & ~wd_expired;
                mem_we       = dcache_we;
                mem_sel      = dcache_sel;
                mem_adr      = dcache_adr;
                dcache_dat_s = mem_dat_s;
                dcache_ack   = mem_ack;
                dcache_rty   = mem_rty | wd_expired;
            end
            default: ;
        endcase
    end

endmodule
